bc_word_sequencer_1553: RTL and testbench
=========================================

# bc_word_sequencer_1553

Upstream feeder for the 1553 Manchester encoder on the BC transmit path. It walks a synchronous word list of 18-bit entries {csw, dw, dword[15:0]} starting at address 0. For each entry it presents one single-cycle command/status or data-word strobe to the encoder, then tracks the encoder's busy handshake and enforces a programmable inter-word gap. It stops on an end-of-list marker, an illegal entry, or a handshake timeout.

## Interface
Parameters:
- ADDR_W, 9, word-list address width (list depth 2^ADDR_W).
- GAP_CYCLES, 4, idle clk cycles inserted after encoder busy falls before the next fetch; legal range 0..255.
- BUSY_TMO, 8, max clk cycles from strobe to tx_busy high before timeout; legal range 1..255.

Ports:
- clk  in  1  encoder clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a list run from address 0 when idle.
- rom_addr  out  ADDR_W  word-list read address; registered.
- rom_data  in  18  list entry; valid exactly one cycle after rom_addr changes (1-cycle synchronous read).
- tx_busy  in  1  encoder busy.
- tx_dword  out  16  word to encoder; equals entry data during the strobe cycle, 0 otherwise.
- tx_csw  out  1  one-cycle command/status sync strobe.
- tx_dw  out  1  one-cycle data sync strobe.
- active  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse on normal list completion.
- err  out  1  sticky; set on illegal entry or timeout; cleared by the next accepted start.
- word_cnt  out  ADDR_W  words issued in the current run; wraps modulo 2^ADDR_W.

## Operation
States: IDLE, FETCH, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: on start, rom_addr←0, word_cnt←0, err←0, go to FETCH. start in any other state is ignored.
- FETCH: one cycle for the read latency. Go to LOAD.
- LOAD: sample rom_data[17:16].
  - 00 = end marker: pulse done, go to IDLE.
  - 11 = illegal entry: set err, go to IDLE, no done pulse.
  - 10 or 01: latch the entry and go to ISSUE.
- ISSUE: drive tx_csw=rom_data[17], tx_dw=rom_data[16], tx_dword=data for exactly one cycle. word_cnt+1. Go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. If BUSY_TMO cycles pass without it, set err and go to IDLE.
- WAIT_DONE: on tx_busy=0, go to GAP. No timeout in this state.
- GAP: count GAP_CYCLES cycles; GAP_CYCLES=0 skips the state. Then advance rom_addr and go to FETCH.
- Address wrap: an address-advance from 2^ADDR_W−1 ends the run as an end marker would (done pulse, IDLE), unless SEQ_LOOP_EN is defined.
- Reset (including mid-run): state IDLE. rom_addr, tx_dword, tx_csw, tx_dw, active, done, err, word_cnt all reset to 0. A strobe in progress is dropped.

## Timing
- start sampled at cycle 0 → FETCH cycle 1 → LOAD cycle 2 → strobe cycle 3.
- Between words: tx_busy first sampled low at cycle t → GAP t+1..t+GAP_CYCLES → FETCH t+GAP_CYCLES+1 → strobe at t+GAP_CYCLES+3.
- A busy already high at the strobe cycle is not accepted; WAIT_BUSY starts counting the cycle after the strobe.
- Timeout: err sets in the cycle after the BUSY_TMO-th cycle with tx_busy low.
- active falls in the same cycle done pulses or err sets.
- A start coincident with a done cycle is ignored.

## Configuration
- SEQ_LOOP_EN:
  - Defined: an end marker or address wrap restarts the list at address 0 (FETCH next cycle, done still pulses, active stays high). An end marker at address 0 terminates normally, so an empty list cannot loop forever.
  - Undefined: the run ends at the end marker or wrap.

## Test plan
- List {2_5555, 1_ABCD, 0_0000}, GAP_CYCLES=4, encoder model busy 3 cycles after strobe for 40 cycles → exactly two strobes: tx_csw with 5555, then tx_dw with ABCD; second strobe 7 cycles after busy falls; done pulses once; word_cnt=2.
- Entry 3_1234 at address 1 → first word issued, then err=1 after LOAD of address 1, no second strobe, no done.
- Model never raises busy, BUSY_TMO=8 → err set 9 cycles after strobe, active=0.
- rst_n asserted during WAIT_DONE of word 3 → all outputs 0 immediately. A subsequent start reissues from address 0 with word_cnt=0.
- Full list with no marker, ADDR_W=3 → 8 strobes then done. With SEQ_LOOP_EN: 9th strobe carries address-0 data.
- start pulses during an active run → ignored; strobe count unchanged.

Source files
------------

// File: rtl/bc_word_sequencer_1553.sv
// bc_word_sequencer_1553: walks the BC word list and strobes the 1553 encoder.
// Define SEQ_LOOP_EN to restart the list on an end marker or address wrap.
module bc_word_sequencer_1553 #(
  parameter int ADDR_W     = 9,
  parameter int GAP_CYCLES = 4,
  parameter int BUSY_TMO   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [17:0]       rom_data,
  input  logic              tx_busy,
  output logic [15:0]       tx_dword,
  output logic              tx_csw,
  output logic              tx_dw,
  output logic              active,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  localparam logic [7:0] GAP_LAST =
    8'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(BUSY_TMO - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [15:0]       dword_q, dword_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              csw_q, csw_d;
  logic              dw_q, dw_d;
  logic              act_q, act_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              adv;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    err_d   = err_q;
    dword_d = '0;
    csw_d   = 1'b0;
    dw_d    = 1'b0;
    done_d  = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // the done cycle is already IDLE, so block a coincident start
        if (start && !done_q) begin
          addr_d  = '0;
          wcnt_d  = '0;
          err_d   = 1'b0;
          act_d   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        unique case (rom_data[17:16])
          2'b00: begin
            done_d = 1'b1;
`ifdef SEQ_LOOP_EN
            if (addr_q != '0) begin
              addr_d  = '0;
              state_d = FETCH;
            end else begin
              act_d   = 1'b0;
              state_d = IDLE;
            end
`else
            act_d   = 1'b0;
            state_d = IDLE;
`endif
          end
          2'b11: begin
            err_d   = 1'b1;
            act_d   = 1'b0;
            state_d = IDLE;
          end
          default: begin
            csw_d   = rom_data[17];
            dw_d    = rom_data[16];
            dword_d = rom_data[15:0];
            state_d = ISSUE;
          end
        endcase
      end
      ISSUE: begin
        wcnt_d  = wcnt_q + 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          act_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d = '0;
          if (GAP_CYCLES == 0) adv = 1'b1;
          else state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) adv = 1'b1;
        else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      if (&addr_q) begin
        done_d = 1'b1;
`ifdef SEQ_LOOP_EN
        addr_d  = '0;
        state_d = FETCH;
`else
        act_d   = 1'b0;
        state_d = IDLE;
`endif
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      dword_q <= '0;
      cnt_q   <= '0;
      csw_q   <= 1'b0;
      dw_q    <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      dword_q <= dword_d;
      cnt_q   <= cnt_d;
      csw_q   <= csw_d;
      dw_q    <= dw_d;
      act_q   <= act_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rom_addr = addr_q;
  assign word_cnt = wcnt_q;
  assign tx_dword = dword_q;
  assign tx_csw   = csw_q;
  assign tx_dw    = dw_q;
  assign active   = act_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bc_word_sequencer_1553.sv
// Bench for bc_word_sequencer_1553: word-list ROM, encoder busy model and
// a list-walking reference model that predicts strobe times and end events.
module tb_bc_word_sequencer_1553;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 8;

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic tx_busy = 0;
  logic [AW-1:0] rom_addr, word_cnt;
  logic [17:0] rom_data;
  logic [15:0] tx_dword;
  logic tx_csw, tx_dw, active, done, err;
  logic [17:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;

  int got_t[$];
  logic [17:0] got_w[$];
  int got_done_n, got_done_t, got_err_t;
  logic got_err1, got_act3;
  logic [26:0] snap;

  int exp_t[$];
  logic [17:0] exp_w[$];
  int exp_done_t, exp_err_t, exp_wc;

  bc_word_sequencer_1553 #(
    .ADDR_W(AW), .GAP_CYCLES(GAP), .BUSY_TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_busy(tx_busy), .tx_dword(tx_dword),
    .tx_csw(tx_csw), .tx_dw(tx_dw),
    .active(active), .done(done), .err(err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= mem[rom_addr];

  // Walk the list: strobe at 3 after start, next strobe after busy
  // window + gap + fetch/load, end events land where a strobe would.
  task automatic model(input int d, input int l);
    int t;
    logic [1:0] tag;
    t = 3;
    exp_t.delete();
    exp_w.delete();
    exp_done_t = -1;
    exp_err_t = -1;
    exp_wc = 0;
    for (int a = 0; a < DEPTH; a++) begin
      tag = mem[a][17:16];
      if (tag == 2'b00) begin exp_done_t = t; return; end
      if (tag == 2'b11) begin exp_err_t = t; return; end
      exp_t.push_back(t);
      exp_w.push_back(mem[a]);
      exp_wc++;
      if (d < 1 || d > TMO) begin exp_err_t = t + TMO + 1; return; end
      t = t + d + l + GAP + 3;
    end
    exp_done_t = t - 2;
  endtask

  task automatic run(input int d, input int l, input int n,
                     input int start_lim, input int rst_at);
    int s;
    s = -1000;
    got_t.delete();
    got_w.delete();
    got_done_n = 0;
    got_done_t = -1;
    got_err_t = -1;
    @(negedge clk);
    start = 1;
    tx_busy = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = 0;
      if (c == rst_at) begin
        rst_n = 0;
        tx_busy = 0;
        #1;
        snap = {rom_addr, word_cnt, tx_dword, tx_csw, tx_dw,
                active, done, err};
        return;
      end
      if (c == 1) got_err1 = err;
      if (c == 3) got_act3 = active;
      if (tx_csw || tx_dw) begin
        got_t.push_back(c);
        got_w.push_back({tx_csw, tx_dw, tx_dword});
        s = c;
      end
      if (done) begin
        got_done_n++;
        if (got_done_t < 0) got_done_t = c;
      end
      if (err && got_err_t < 0) got_err_t = c;
      tx_busy = (d > 0) && (c >= s + d) && (c < s + d + l);
      if (c < start_lim && $urandom_range(2) == 0) start = 1;
      if (c == start_lim) start = 1;
    end
    start = 0;
    tx_busy = 0;
  endtask

  function automatic int run_len();
    return (exp_done_t > exp_err_t ? exp_done_t : exp_err_t) + 8;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rom_addr, word_cnt, tx_dword} !== '0) begin
      errors++;
      $display("FAIL reset_words got=%0h/%0h/%0h exp=0/0/0",
               rom_addr, word_cnt, tx_dword);
    end
    checks++;
    if ({tx_csw, tx_dw, active, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000",
               {tx_csw, tx_dw, active, done, err});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    string nm;
    int d, l;
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < DEPTH; a++) mem[a] = '0;
      unique case (k)
        0: begin
          nm = "basic"; d = 3; l = 40;
          mem[0] = 18'h25555; mem[1] = 18'h1ABCD;
        end
        1: begin
          nm = "illegal"; d = 2; l = 5;
          mem[0] = 18'h20F0F; mem[1] = 18'h31234;
        end
        2: begin
          nm = "timeout"; d = 0; l = 0;
          mem[0] = 18'h1BEEF; mem[1] = 18'h24321;
        end
        default: begin
          nm = "wrap"; d = 4; l = 3;
          for (int a = 0; a < DEPTH; a++)
            mem[a] = {(a % 2 == 0) ? 2'b10 : 2'b01, 16'($urandom)};
        end
      endcase
      model(d, l);
      run(d, l, run_len(), -1, -1);
      checks++;
      if (got_t.size() != exp_t.size()) begin
        errors++;
        $display("FAIL %s strobe_count got=%0d exp=%0d",
                 nm, got_t.size(), exp_t.size());
      end
      for (int i = 0; i < got_t.size() && i < exp_t.size(); i++) begin
        checks++;
        if (got_t[i] != exp_t[i] || got_w[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL %s strobe%0d got=@%0d %05h exp=@%0d %05h",
                   nm, i, got_t[i], got_w[i], exp_t[i], exp_w[i]);
        end
      end
      checks++;
      if (got_done_t != exp_done_t ||
          got_done_n != (exp_done_t >= 0 ? 1 : 0)) begin
        errors++;
        $display("FAIL %s done got=@%0d x%0d exp=@%0d",
                 nm, got_done_t, got_done_n, exp_done_t);
      end
      checks++;
      if (got_err_t != exp_err_t) begin
        errors++;
        $display("FAIL %s err_time got=%0d exp=%0d",
                 nm, got_err_t, exp_err_t);
      end
      checks++;
      if (word_cnt !== AW'(exp_wc) || active !== 1'b0 ||
          err !== (exp_err_t >= 0) || got_err1 !== 1'b0 ||
          got_act3 !== (exp_done_t != 3 && exp_err_t != 3)) begin
        errors++;
        $display("FAIL %s final got=cnt%0d act%b err%b e1%b a3%b exp=cnt%0d",
                 nm, word_cnt, active, err, got_err1, got_act3,
                 AW'(exp_wc));
      end
    end
  endtask

  task automatic test_random();
    int d, l, n;
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(0, DEPTH);
      for (int a = 0; a < DEPTH; a++)
        mem[a] = {($urandom_range(1) == 1) ? 2'b10 : 2'b01,
                  16'($urandom)};
      if (n < DEPTH)
        mem[n] = {($urandom_range(3) == 0) ? 2'b11 : 2'b00,
                  16'($urandom)};
      d = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, TMO + 1);
      l = $urandom_range(1, 6);
      model(d, l);
      run(d, l, run_len(), -1, -1);
      checks++;
      if (got_t.size() != exp_t.size()) begin
        errors++;
        $display("FAIL rand%0d strobe_count got=%0d exp=%0d",
                 k, got_t.size(), exp_t.size());
      end
      for (int i = 0; i < got_t.size() && i < exp_t.size(); i++) begin
        checks++;
        if (got_t[i] != exp_t[i] || got_w[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL rand%0d strobe%0d got=@%0d %05h exp=@%0d %05h",
                   k, i, got_t[i], got_w[i], exp_t[i], exp_w[i]);
        end
      end
      checks++;
      if (got_done_t != exp_done_t || got_err_t != exp_err_t ||
          got_done_n != (exp_done_t >= 0 ? 1 : 0)) begin
        errors++;
        $display("FAIL rand%0d end got=d@%0d x%0d e@%0d exp=d@%0d e@%0d",
                 k, got_done_t, got_done_n, got_err_t,
                 exp_done_t, exp_err_t);
      end
      checks++;
      if (word_cnt !== AW'(exp_wc) || active !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d final got=cnt%0d act%b exp=cnt%0d act0",
                 k, word_cnt, active, AW'(exp_wc));
      end
    end
  endtask

  task automatic test_back_to_back();
    int d, l, n;
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, DEPTH - 1);
      for (int a = 0; a < DEPTH; a++)
        mem[a] = {2'b10, 16'($urandom)};
      mem[n] = {2'b00, 16'($urandom)};
      d = $urandom_range(1, TMO);
      l = $urandom_range(1, 6);
      model(d, l);
      run(d, l, run_len(), exp_done_t, -1);
      checks++;
      if (got_t.size() != exp_t.size()) begin
        errors++;
        $display("FAIL b2b%0d strobe_count got=%0d exp=%0d",
                 k, got_t.size(), exp_t.size());
      end
      for (int i = 0; i < got_t.size() && i < exp_t.size(); i++) begin
        checks++;
        if (got_t[i] != exp_t[i] || got_w[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL b2b%0d strobe%0d got=@%0d %05h exp=@%0d %05h",
                   k, i, got_t[i], got_w[i], exp_t[i], exp_w[i]);
        end
      end
      checks++;
      if (got_done_t != exp_done_t || got_done_n != 1 ||
          active !== 1'b0 || word_cnt !== AW'(exp_wc)) begin
        errors++;
        $display("FAIL b2b%0d end got=d@%0d x%0d act%b cnt%0d exp=d@%0d x1",
                 k, got_done_t, got_done_n, active, word_cnt, exp_done_t);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int d, l;
    d = 3;
    l = 6;
    for (int a = 0; a < DEPTH; a++) mem[a] = {2'b01, 16'($urandom)};
    mem[0] = 18'h2C0DE;
    mem[4] = 18'h00000;
    model(d, l);
    run(d, l, run_len(), -1, exp_t[2] + d + 1);
    checks++;
    if (snap !== '0) begin
      errors++;
      $display("FAIL midrun_reset outputs got=%07h exp=0000000", snap);
    end
    @(negedge clk);
    rst_n = 1;
    checks++;
    if (word_cnt !== '0 || rom_addr !== '0) begin
      errors++;
      $display("FAIL midrun_idle got=cnt%0d addr%0d exp=0/0",
               word_cnt, rom_addr);
    end
    run(d, l, run_len(), -1, -1);
    checks++;
    if (got_t.size() != exp_t.size()) begin
      errors++;
      $display("FAIL rerun strobe_count got=%0d exp=%0d",
               got_t.size(), exp_t.size());
    end
    for (int i = 0; i < got_t.size() && i < exp_t.size(); i++) begin
      checks++;
      if (got_t[i] != exp_t[i] || got_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL rerun strobe%0d got=@%0d %05h exp=@%0d %05h",
                 i, got_t[i], got_w[i], exp_t[i], exp_w[i]);
      end
    end
    checks++;
    if (got_done_t != exp_done_t || word_cnt !== AW'(exp_wc)) begin
      errors++;
      $display("FAIL rerun end got=d@%0d cnt%0d exp=d@%0d cnt%0d",
               got_done_t, word_cnt, exp_done_t, AW'(exp_wc));
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
